md_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same forwarded operands the ALU uses (alu_a = rs, alu_b = rt, after forwarding mux).
- Owns the HI/LO architectural registers and executes mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Drives a stall request to the hazard unit while an operation is in flight.

---
 rtl/cpu_defs.sv | 37 +++
 rtl/md_core.sv | 143 ++++++++++++++
 rtl/md_unit.sv | 124 ++++++++++++
 tb/tb_md_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared by the multiply/divide unit.
// Holds the funct codes of the eight HI/LO instructions, the iteration FSM
// state encoding, the multiply/divide op type, and decode helpers.
package cpu_defs;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  // Any of the eight instructions that touch HI/LO.
  function automatic logic is_md_op(input logic [5:0] f);
    return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                     FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  // Instructions that launch the iterative datapath.
  function automatic logic is_iter_op(input logic [5:0] f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

endpackage

// File: rtl/md_core.sv
// md_core: iterative radix-2 multiply / restoring divide datapath.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              launch an operation (only honoured while idle)
//   op_div             1 = divide, 0 = multiply
//   neg_q              negate the product (mul) or quotient (div) at the end
//   neg_r              negate the remainder (div only)
//   opa, opb           magnitudes: multiplier/multiplicand or dividend/divisor
//   busy               operation in flight (RUN or FIX)
//   done               FIX cycle: res_hi/res_lo are final and must be written
//   res_hi, res_lo     sign-corrected result {HI, LO}
module md_core
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;

  // Multiply step: conditionally add multiplicand into the upper half, then
  // shift the whole accumulator right, carry bit included.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Divide step: shift next dividend bit into the partial remainder, try to
  // subtract the divisor, keep the difference only when it did not borrow.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               unused_diff_bit;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, dsr_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, dsr_q};
    if (!div_diff[WIDTH+1]) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // A non-borrowing difference is below the divisor, so its top bit is zero.
  assign unused_diff_bit = div_diff[WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = op_div ? OP_DIV : OP_MUL;
          cnt_d   = CNT_W'(WIDTH - 1);
          acc_d   = {{WIDTH{1'b0}}, opa};
          dsr_d   = opb;
          neg_q_d = neg_q;
          neg_r_d = neg_r;
        end
      end
      ST_RUN: begin
        acc_d = (op_q == OP_DIV) ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  // Sign correction: a product is negated as one 64-bit value, a quotient and
  // remainder are negated independently.
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    if (op_q == OP_DIV) begin
      res_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_q_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIX);

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   IE_MDValid    live R-type instruction in EX
//   IE_Go         EX instruction advances this edge (excludes MD_Stall)
//   IE_Funct      funct field of the EX instruction
//   alu_a, alu_b  forwarded rs / rt operands
//   MD_Stall      hold IF/ID/EX: HI/LO instruction in EX while busy
//   MD_Busy       multiply/divide in flight
//   MD_Result     mfhi/mflo read data (0 for other functs)
//   HI, LO        architectural HI/LO registers
module md_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IE_MDValid,
  input  logic             IE_Go,
  input  logic [5:0]       IE_Funct,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             MD_Stall,
  output logic             MD_Busy,
  output logic [WIDTH-1:0] MD_Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             core_busy, core_done;
  logic [WIDTH-1:0] core_hi, core_lo;

  logic             is_div, is_sgn, issue_ok, start;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_q, neg_r;

  always_comb begin
    is_div   = (IE_Funct == FN_DIV)  || (IE_Funct == FN_DIVU);
    is_sgn   = (IE_Funct == FN_MULT) || (IE_Funct == FN_DIV);
    issue_ok = IE_MDValid & IE_Go & ~core_busy;
    start    = issue_ok & is_iter_op(IE_Funct);

    a_neg  = is_sgn & alu_a[WIDTH-1];
    b_neg  = is_sgn & alu_b[WIDTH-1];
    b_zero = (alu_b == '0);
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    a_mag  = a_neg ? -alu_a : alu_a;
    b_mag  = b_neg ? -alu_b : alu_b;

    // Divide by zero yields all-ones quotient and remainder = dividend; with
    // a zero divisor the core produces |a| as remainder, so restoring the
    // dividend sign gives back alu_a, and the quotient must stay unnegated.
    if (is_div) begin
      neg_q = b_zero ? 1'b0 : (a_neg ^ b_neg);
      neg_r = a_neg;
    end else begin
      neg_q = a_neg ^ b_neg;
      neg_r = 1'b0;
    end
  end

  md_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_div (is_div),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .opa    (a_mag),
    .opb    (b_mag),
    .busy   (core_busy),
    .done   (core_done),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (core_done) begin
      hi_d = core_hi;
      lo_d = core_lo;
    end else if (issue_ok && IE_Funct == FN_MTHI) begin
      hi_d = alu_a;
    end else if (issue_ok && IE_Funct == FN_MTLO) begin
      lo_d = alu_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    if (IE_Funct == FN_MFHI) begin
      MD_Result = hi_q;
    end else if (IE_Funct == FN_MFLO) begin
      MD_Result = lo_q;
    end else begin
      MD_Result = '0;
    end
  end

  assign MD_Busy  = core_busy;
  assign MD_Stall = IE_MDValid & is_md_op(IE_Funct) & core_busy;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with directed corner cases and
// randomized multiply/divide traffic against an arithmetic reference model.
module tb_md_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IE_MDValid, IE_Go;
  logic [5:0]  IE_Funct;
  logic [31:0] alu_a, alu_b;
  logic        MD_Stall, MD_Busy;
  logic [31:0] MD_Result, HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IE_MDValid (IE_MDValid),
    .IE_Go      (IE_Go),
    .IE_Funct   (IE_Funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .MD_Stall   (MD_Stall),
    .MD_Busy    (MD_Busy),
    .MD_Result  (MD_Result),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      FN_MULT:  return 64'(sa * sb);
      FN_MULTU: return ua * ub;
      FN_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      FN_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    IE_MDValid = 1'b0;
    IE_Go      = 1'b1;
    IE_Funct   = 6'b100000;
    alu_a      = '0;
    alu_b      = '0;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    IE_MDValid = 1'b1;
    IE_Go      = 1'b1;
    IE_Funct   = f;
    alu_a      = a;
    alu_b      = b;
  endtask

  // Count busy cycles sampled on falling edges; returns at the first idle one.
  task automatic wait_idle(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (!MD_Busy) break;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [5:0] f,
                              input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = ref_md(f, a, b);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  // Issue one op (called #1 after a rising edge), wait for completion, check.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    drive(f, a, b);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle(n);
    chk({tag, "_busy"}, n, 33);
    check_result(tag, f, a, b);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] fn_tab [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};

  initial begin
    int n;
    logic [31:0] a, b;
    logic [5:0]  f;

    // Reset state, with an HI/LO op presented during reset.
    idle_inputs();
    rst_n = 1'b0;
    drive(FN_MULT, 32'h5, 32'h7);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", MD_Busy, 0);
    chk("rst_stall", MD_Stall, 0);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_busy", MD_Busy, 0);

    // Directed vectors.
    run_op("mult", FN_MULT, 32'hFFFF_FFFE, 32'd3);
    run_op("multu", FN_MULTU, 32'hFFFF_FFFE, 32'd3);
    run_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_z", FN_DIVU, 32'd7, 32'd0);
    run_op("div_z_neg", FN_DIV, 32'hFFFF_FF00, 32'd0);
    run_op("div_rsign", FN_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("mult_min", FN_MULT, 32'h8000_0000, 32'h8000_0000);

    // divu, unrelated op, then mflo stalled behind it.
    drive(FN_DIVU, 32'd1000, 32'd7);
    @(posedge clk); #1;
    IE_Funct = 6'b100000;
    alu_a = '0;
    alu_b = '0;
    @(negedge clk);
    chk("nonmd_stall", MD_Stall, 0);
    @(posedge clk); #1;
    drive(FN_MFLO, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!MD_Busy) break;
      if (MD_Stall) n++;
    end
    chk("mflo_stall_cycles", n, 32);
    chk("mflo_stall_off", MD_Stall, 0);
    chk("mflo_result", MD_Result, 32'd142);
    exp_hi = 32'd6;
    exp_lo = 32'd142;
    @(posedge clk); #1;

    // mthi then mfhi back to back; LO untouched.
    drive(FN_MTHI, 32'h1234, 32'd0);
    @(posedge clk); #1;
    drive(FN_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("mfhi_fwd", MD_Result, 32'h1234);
    chk("mthi_lo_kept", LO, exp_lo);
    @(posedge clk); #1;
    drive(FN_MTLO, 32'h5555, 32'd0);
    @(posedge clk); #1;
    drive(FN_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo_fwd", MD_Result, 32'h5555);
    chk("mtlo_hi_kept", HI, 32'h1234);
    @(posedge clk); #1;

    // Reset at E10 of a mult aborts it.
    drive(FN_MULT, 32'd1234567, 32'd89);
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    chk("e10_busy", MD_Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    chk("abort_busy", MD_Busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IE_Go low for 3 edges: no start.
    drive(FN_MULT, 32'hFFFF_FFF0, 32'd16);
    IE_Go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("nogo_busy%0d", i), MD_Busy, 0);
    end
    IE_Go = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    wait_idle(n);
    chk("go_busy", n, 33);
    check_result("go", FN_MULT, 32'hFFFF_FFF0, 32'd16);
    @(posedge clk); #1;

    // Second mult issued while busy stalls, then starts once idle.
    drive(FN_MULT, 32'd300, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    drive(FN_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!MD_Stall) break;
      n++;
    end
    chk("b2b_stall_cycles", n, 33);
    check_result("b2b_first", FN_MULT, 32'd300, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle(n);
    chk("b2b_busy", n, 33);
    check_result("b2b_second", FN_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      f = fn_tab[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), f, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
